// File: rtl/vend_credit_ctrl.sv
// Credit/dispense sequencer for the vending machine: accumulates coins, arbitrates
// buy/cancel against the item price and drives the credit/price display select.
module vend_credit_ctrl #(
    parameter int unsigned SHOW_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid_i,
    input  logic [7:0] coin_value_i,
    input  logic       buy_i,
    input  logic       cancel_i,
    input  logic [7:0] price_i,
    output logic       disp_sel_o,
    output logic [7:0] credit_o,
    output logic       coin_reject_o,
    output logic       dispense_o,
    output logic       change_valid_o,
    output logic [7:0] change_amt_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {StCredit, StShowPrice, StDispense, StChange} state_e;

    state_e             state_q, state_d;
    logic [7:0]         credit_q, credit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         price_q, price_d;
    logic               disp_sel_q, disp_sel_d;
    logic               coin_reject_q, coin_reject_d;
    logic               dispense_q, dispense_d;
    logic               change_valid_q, change_valid_d;
    logic [7:0]         change_amt_q, change_amt_d;
    logic               busy_q, busy_d;

    logic               coin_ok;
    logic [8:0]         sum;
    logic [7:0]         remainder;

    assign sum       = {1'b0, credit_q} + {1'b0, coin_value_i};
    assign remainder = credit_q - price_q;

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        cnt_d          = cnt_q;
        price_d        = price_q;
        disp_sel_d     = disp_sel_q;
        coin_reject_d  = 1'b0;
        dispense_d     = 1'b0;
        change_valid_d = 1'b0;
        change_amt_d   = 8'd0;
        busy_d         = 1'b0;
        coin_ok        = 1'b0;

        unique case (state_q)
            StCredit: begin
                if (cancel_i && (credit_q != 8'd0)) begin
                    state_d        = StChange;
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                    busy_d         = 1'b1;
                    coin_reject_d  = coin_valid_i;
                end else if (buy_i) begin
                    if ((price_i != 8'd0) && (credit_q >= price_i)) begin
                        state_d       = StDispense;
                        price_d       = price_i;
                        dispense_d    = 1'b1;
                        busy_d        = 1'b1;
                        coin_reject_d = coin_valid_i;
                    end else begin
                        // Rejected buy is not an accepted request, so a coin still lands.
                        state_d    = StShowPrice;
                        price_d    = price_i;
                        disp_sel_d = 1'b1;
                        cnt_d      = CNT_W'(SHOW_CYCLES - 1);
                        coin_ok    = 1'b1;
                    end
                end else begin
                    coin_ok = 1'b1;
                end
            end
            StShowPrice: begin
                if (cancel_i) begin
                    disp_sel_d    = 1'b0;
                    coin_reject_d = coin_valid_i;
                    if (credit_q != 8'd0) begin
                        state_d        = StChange;
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                        busy_d         = 1'b1;
                    end else begin
                        state_d = StCredit;
                    end
                end else begin
                    coin_ok = 1'b1;
                    if (cnt_q == '0) begin
                        state_d    = StCredit;
                        disp_sel_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StDispense: begin
                coin_reject_d = coin_valid_i;
                credit_d      = remainder;
                if (remainder != 8'd0) begin
                    state_d        = StChange;
                    change_valid_d = 1'b1;
                    change_amt_d   = remainder;
                    busy_d         = 1'b1;
                end else begin
                    state_d = StCredit;
                end
            end
            StChange: begin
                coin_reject_d = coin_valid_i;
                credit_d      = 8'd0;
                state_d       = StCredit;
            end
            default: begin
                state_d = StCredit;
            end
        endcase

        if (coin_ok && coin_valid_i) begin
            if (sum[8]) begin
                coin_reject_d = 1'b1;
            end else begin
                credit_d = sum[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StCredit;
            credit_q       <= 8'd0;
            cnt_q          <= '0;
            price_q        <= 8'd0;
            disp_sel_q     <= 1'b0;
            coin_reject_q  <= 1'b0;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= 8'd0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            cnt_q          <= cnt_d;
            price_q        <= price_d;
            disp_sel_q     <= disp_sel_d;
            coin_reject_q  <= coin_reject_d;
            dispense_q     <= dispense_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            busy_q         <= busy_d;
        end
    end

    assign disp_sel_o     = disp_sel_q;
    assign credit_o       = credit_q;
    assign coin_reject_o  = coin_reject_q;
    assign dispense_o     = dispense_q;
    assign change_valid_o = change_valid_q;
    assign change_amt_o   = change_amt_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: each step queues the expected output word
// for the cycle after its stimulus and compares it once that cycle is reached.
module tb_vend_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = 8'd0;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    logic [7:0] price = 8'd0;
    logic       disp_sel;
    logic [7:0] credit;
    logic       coin_reject;
    logic       dispense;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       busy;

    int runs = 0;
    int fails = 0;

    typedef struct {
        logic        cv;
        logic [7:0]  val;
        logic        b;
        logic        c;
        logic [7:0]  p;
        logic [20:0] e;
    } stim_t;

    logic [20:0] exp_q[$];

    vend_credit_ctrl #(.SHOW_CYCLES(4), .CNT_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_valid_i  (coin_valid),
        .coin_value_i  (coin_value),
        .buy_i         (buy),
        .cancel_i      (cancel),
        .price_i       (price),
        .disp_sel_o    (disp_sel),
        .credit_o      (credit),
        .coin_reject_o (coin_reject),
        .dispense_o    (dispense),
        .change_valid_o(change_valid),
        .change_amt_o  (change_amt),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Output word: {disp_sel, credit, coin_reject, dispense, change_valid, change_amt, busy}
    function automatic logic [20:0] ev(logic ds, logic [7:0] cr, logic rj, logic dp,
                                       logic cv, logic [7:0] amt, logic bz);
        return {ds, cr, rj, dp, cv, amt, bz};
    endfunction

    function automatic logic [20:0] obs();
        return {disp_sel, credit, coin_reject, dispense, change_valid, change_amt, busy};
    endfunction

    function automatic stim_t mk(logic cv, logic [7:0] val, logic b, logic c, logic [7:0] p,
                                 logic [20:0] e);
        stim_t s;
        s.cv = cv; s.val = val; s.b = b; s.c = c; s.p = p; s.e = e;
        return s;
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic cyc(stim_t s);
        coin_valid = s.cv; coin_value = s.val; buy = s.b; cancel = s.c; price = s.p;
        @(posedge clk);
        #1;
        coin_valid = 1'b0; coin_value = 8'd0; buy = 1'b0; cancel = 1'b0; price = 8'd0;
    endtask

    task automatic test_reset();
        logic [20:0] got;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = obs();
        runs++;
        if (got !== 21'd0) begin
            fails++;
            $display("FAIL reset: got %h expected %h", got, 21'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_coins();
        stim_t st[$];
        logic [20:0] got, e;
        st.push_back(mk(1, 25, 0, 0, 0, ev(0, 25, 0, 0, 0, 0, 0)));
        st.push_back(mk(1, 25, 0, 0, 0, ev(0, 50, 0, 0, 0, 0, 0)));
        st.push_back(mk(1, 50, 0, 0, 0, ev(0, 100, 0, 0, 0, 0, 0)));
        foreach (st[i]) begin
            exp_q.push_back(st[i].e);
            cyc(st[i]);
            got = obs();
            e = exp_q.pop_front();
            runs++;
            if (got !== e) begin
                fails++;
                $display("FAIL coins step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_dispense_change();
        stim_t st[$];
        logic [20:0] got, e;
        st.push_back(mk(0, 0, 1, 0, 75, ev(0, 100, 0, 1, 0, 0, 1)));
        st.push_back(mk(1, 10, 0, 0, 0, ev(0, 25, 1, 0, 1, 25, 1)));
        st.push_back(mk(0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
        foreach (st[i]) begin
            exp_q.push_back(st[i].e);
            cyc(st[i]);
            got = obs();
            e = exp_q.pop_front();
            runs++;
            if (got !== e) begin
                fails++;
                $display("FAIL dispense_change step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_show_price();
        stim_t st[$];
        logic [20:0] got, e;
        st.push_back(mk(1, 50, 0, 0, 0, ev(0, 50, 0, 0, 0, 0, 0)));
        for (int r = 0; r < 2; r++) begin
            st.push_back(mk(0, 0, 1, 0, (r == 0) ? 8'd75 : 8'd0, ev(1, 50, 0, 0, 0, 0, 0)));
            for (int k = 0; k < 3; k++) st.push_back(mk(0, 0, 0, 0, 0, ev(1, 50, 0, 0, 0, 0, 0)));
            st.push_back(mk(0, 0, 0, 0, 0, ev(0, 50, 0, 0, 0, 0, 0)));
        end
        // Cancel during the price window leaves at once and refunds.
        st.push_back(mk(0, 0, 1, 0, 90, ev(1, 50, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 0, 1, 0, ev(0, 50, 0, 0, 1, 50, 1)));
        st.push_back(mk(0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
        foreach (st[i]) begin
            exp_q.push_back(st[i].e);
            cyc(st[i]);
            got = obs();
            e = exp_q.pop_front();
            runs++;
            if (got !== e) begin
                fails++;
                $display("FAIL show_price step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_overflow();
        stim_t st[$];
        logic [20:0] got, e;
        st.push_back(mk(1, 250, 0, 0, 0, ev(0, 250, 0, 0, 0, 0, 0)));
        st.push_back(mk(1, 10, 0, 0, 0, ev(0, 250, 1, 0, 0, 0, 0)));
        st.push_back(mk(1, 5, 0, 0, 0, ev(0, 255, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 0, 1, 0, ev(0, 255, 0, 0, 1, 255, 1)));
        st.push_back(mk(0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 0, 1, 0, ev(0, 0, 0, 0, 0, 0, 0)));
        foreach (st[i]) begin
            exp_q.push_back(st[i].e);
            cyc(st[i]);
            got = obs();
            e = exp_q.pop_front();
            runs++;
            if (got !== e) begin
                fails++;
                $display("FAIL overflow step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_priority();
        stim_t st[$];
        logic [20:0] got, e;
        st.push_back(mk(1, 40, 0, 0, 0, ev(0, 40, 0, 0, 0, 0, 0)));
        st.push_back(mk(1, 25, 1, 1, 40, ev(0, 40, 1, 0, 1, 40, 1)));
        st.push_back(mk(0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
        foreach (st[i]) begin
            exp_q.push_back(st[i].e);
            cyc(st[i]);
            got = obs();
            e = exp_q.pop_front();
            runs++;
            if (got !== e) begin
                fails++;
                $display("FAIL priority step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[$];
        logic [20:0] got, e;
        st.push_back(mk(1, 100, 0, 0, 0, ev(0, 100, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 0, 75, ev(0, 100, 0, 1, 0, 0, 1)));
        foreach (st[i]) begin
            exp_q.push_back(st[i].e);
            cyc(st[i]);
            got = obs();
            e = exp_q.pop_front();
            runs++;
            if (got !== e) begin
                fails++;
                $display("FAIL reset_mid step %0d: got %h expected %h", i, got, e);
            end
        end
        rst_n = 1'b0;
        #1;
        got = obs();
        runs++;
        if (got !== 21'd0) begin
            fails++;
            $display("FAIL reset_mid async: got %h expected %h", got, 21'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(21'd0);
            cyc(mk(0, 0, 0, 0, 0, 21'd0));
            got = obs();
            e = exp_q.pop_front();
            runs++;
            if (got !== e) begin
                fails++;
                $display("FAIL reset_mid after %0d: got %h expected %h", k, got, e);
            end
        end
    endtask

    task automatic test_exact_price();
        stim_t st[$];
        logic [20:0] got, e;
        st.push_back(mk(1, 60, 0, 0, 0, ev(0, 60, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 1, 0, 60, ev(0, 60, 0, 1, 0, 0, 1)));
        st.push_back(mk(0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk(0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0)));
        foreach (st[i]) begin
            exp_q.push_back(st[i].e);
            cyc(st[i]);
            got = obs();
            e = exp_q.pop_front();
            runs++;
            if (got !== e) begin
                fails++;
                $display("FAIL exact_price step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_coins();
        test_dispense_change();
        test_show_price();
        test_overflow();
        test_priority();
        test_reset_mid();
        test_exact_price();
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

endmodule
